// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, per-frame parity, framing and
// break status, and a small ready/valid frame FIFO on the clk side.
module uart_rx_fifo #(
    parameter int BITWIDTH   = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIVISOR    = 2,
    parameter int PARITY     = 0,
    parameter int STOPBITS   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxi,
    output logic [BITWIDTH-1:0]           data,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          break_det,
    output logic                          valid,
    input  logic                          ready,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int DW  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BIW = $clog2(BITWIDTH);
    localparam int EW  = BITWIDTH + 3;

    localparam logic [SW-1:0]  SC_S0   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0]  SC_S1   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0]  SC_S2   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0]  SC_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [DW-1:0]  DIV_LAST = DW'(DIVISOR - 1);
    localparam logic [BIW-1:0] BIT_LAST = BIW'(BITWIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRKWAIT} state_t;

    // Front end: synchroniser, previous-sample register and post-reset arming
    logic       sync1_q, sync1_d, sync2_q, sync2_d, s_prev_q, s_prev_d;
    logic [1:0] arm_q, arm_d;
    logic       s, start_edge;

    // Receive FSM and datapath
    state_t              state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [SW-1:0]       sc_q, sc_d;
    logic [BIW-1:0]      bit_q, bit_d;
    logic                stop_q, stop_d;
    logic                samp0_q, samp0_d, samp1_q, samp1_d;
    logic [BITWIDTH-1:0] shreg_q, shreg_d;
    logic                par_bit_q, par_bit_d, pe_q, pe_d, fe_q, fe_d;
    logic                push_q, push_d;
    logic [EW-1:0]       push_entry_q, push_entry_d;
    logic                tick, decide, wrap, maj, fe_new, brk_new;

    // Frame FIFO
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          pop, full, wr_en;
    logic [EW-1:0] head;

    assign s          = sync2_q;
    assign start_edge = (arm_q == 2'd3) && s_prev_q && !s;
    assign tick       = (state_q != IDLE) && (div_q == DIV_LAST);
    assign decide     = tick && (sc_q == SC_S2);
    assign wrap       = tick && (sc_q == SC_LAST);
    assign maj        = (samp0_q & samp1_q) | (samp0_q & s) | (samp1_q & s);
    assign fe_new     = fe_q | ~maj;
    assign brk_new    = (shreg_q == '0) && fe_new && ((PARITY == 0) || !par_bit_q);

    // Next values for the synchroniser; start edges only count once the
    // edge detector holds real line samples rather than reset values
    always_comb begin
        sync1_d  = rxi;
        sync2_d  = sync1_q;
        s_prev_d = sync2_q;
        arm_d    = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    end

    // Bit-timing, sampling and frame assembly state machine
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        sc_d         = sc_q;
        bit_d        = bit_q;
        stop_d       = stop_q;
        samp0_d      = samp0_q;
        samp1_d      = samp1_q;
        shreg_d      = shreg_q;
        par_bit_d    = par_bit_q;
        pe_d         = pe_q;
        fe_d         = fe_q;
        push_d       = 1'b0;
        push_entry_d = push_entry_q;

        if (state_q == IDLE || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end

        if (tick) begin
            sc_d = wrap ? '0 : sc_q + SW'(1);
            if (sc_q == SC_S0) samp0_d = s;
            if (sc_q == SC_S1) samp1_d = s;
        end

        case (state_q)
            IDLE: begin
                sc_d = '0;
                if (start_edge) begin
                    state_d = START;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    state_d   = DATA;
                    bit_d     = '0;
                    stop_d    = 1'b0;
                    pe_d      = 1'b0;
                    fe_d      = 1'b0;
                    par_bit_d = 1'b0;
                end
            end
            DATA: begin
                if (decide) begin
                    shreg_d = {maj, shreg_q[BITWIDTH-1:1]};
                end
                if (wrap) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_d = bit_q + BIW'(1);
                    end
                end
            end
            PAR: begin
                if (decide) begin
                    par_bit_d = maj;
                    pe_d      = (^{shreg_q, maj}) != (PARITY == 1);
                end
                if (wrap) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    fe_d = fe_new;
                    if (STOPBITS == 1 || stop_q) begin
                        push_d       = 1'b1;
                        push_entry_d = {brk_new, fe_new, pe_q, shreg_q};
                        state_d      = brk_new ? BRKWAIT : IDLE;
                    end
                end else if (wrap) begin
                    stop_d = 1'b1;
                end
            end
            BRKWAIT: begin
                if (tick && s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: a push while full is dropped unless a pop frees the slot
    always_comb begin
        full  = (cnt_q == LW'(FIFO_DEPTH));
        pop   = (cnt_q != '0) && ready;
        wr_en = push_q && (!full || pop);
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_q] = push_entry_q;
        end
        wr_d = wr_en ? wr_q + PW'(1) : wr_q;
        rd_d = pop ? rd_q + PW'(1) : rd_q;
        cnt_d = cnt_q;
        if (wr_en && !pop) begin
            cnt_d = cnt_q + LW'(1);
        end else if (pop && !wr_en) begin
            cnt_d = cnt_q - LW'(1);
        end
    end

    assign overrun    = push_q && full && !pop;
    assign valid      = (cnt_q != '0);
    assign level      = cnt_q;
    assign head       = valid ? mem_q[rd_q] : '0;
    assign data       = head[BITWIDTH-1:0];
    assign parity_err = head[BITWIDTH];
    assign frame_err  = head[BITWIDTH+1];
    assign break_det  = head[BITWIDTH+2];

    // Synchroniser and edge-detector registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            s_prev_q <= 1'b1;
            arm_q    <= 2'd0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            s_prev_q <= s_prev_d;
            arm_q    <= arm_d;
        end
    end

    // Receive state register and frame datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            div_q        <= '0;
            sc_q         <= '0;
            bit_q        <= '0;
            stop_q       <= 1'b0;
            samp0_q      <= 1'b1;
            samp1_q      <= 1'b1;
            shreg_q      <= '0;
            par_bit_q    <= 1'b0;
            pe_q         <= 1'b0;
            fe_q         <= 1'b0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            sc_q         <= sc_d;
            bit_q        <= bit_d;
            stop_q       <= stop_d;
            samp0_q      <= samp0_d;
            samp1_q      <= samp1_d;
            shreg_q      <= shreg_d;
            par_bit_q    <= par_bit_d;
            pe_q         <= pe_d;
            fe_q         <= fe_d;
            push_q       <= push_d;
            push_entry_q <= push_entry_d;
        end
    end

    // FIFO storage and pointers; reset flushes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: default 8N1 instance plus an even-parity
// instance, each on its own serial line.
module tb_uart_rx_fifo;

    localparam int BITCLK = 32;

    logic       clk = 1'b0;
    logic       rst, rxi, rxi_p, ready, ready_p;
    logic [7:0] data, data_p;
    logic       parity_err, frame_err, break_det, valid, overrun;
    logic       parity_err_p, frame_err_p, break_det_p, valid_p, overrun_p;
    logic [2:0] level, level_p;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int stim_cyc = 0;
    int pop_cnt = 0;
    int non55 = 0;
    int ovr_cnt = 0;
    int ovr_cyc = 0;
    int base, base2, offset;
    logic [7:0] last_data = 8'h00;
    logic [2:0] last_flags = 3'b000;
    logic [7:0] drain_exp [4] = '{8'h02, 8'h03, 8'h04, 8'h07};

    uart_rx_fifo dut (
        .clk(clk), .rst(rst), .rxi(rxi), .data(data), .parity_err(parity_err),
        .frame_err(frame_err), .break_det(break_det), .valid(valid), .ready(ready),
        .overrun(overrun), .level(level)
    );

    uart_rx_fifo #(.PARITY(2)) dut_p (
        .clk(clk), .rst(rst), .rxi(rxi_p), .data(data_p), .parity_err(parity_err_p),
        .frame_err(frame_err_p), .break_det(break_det_p), .valid(valid_p), .ready(ready_p),
        .overrun(overrun_p), .level(level_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record accepted frames and overrun pulses of the default instance
    always @(negedge clk) begin
        if (valid && ready) begin
            pop_cnt++;
            last_data  = data;
            last_flags = {break_det, frame_err, parity_err};
            if (data != 8'h55 || {break_det, frame_err, parity_err} != 3'b000) non55++;
        end
        if (overrun) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
    end

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic stepN(input int n);
        repeat (n) stepClk();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setLine(input int line, input logic v);
        if (line == 0) rxi = v;
        else rxi_p = v;
    endtask

    // Start bit, then nb bits of fr LSB first, then idle high for gap clocks
    task automatic applyStimulus(input int line, input logic [15:0] fr, input int nb,
                                 input int bitclk, input int gap);
        setLine(line, 1'b0);
        stim_cyc = cyc;
        stepN(bitclk);
        for (int i = 0; i < nb; i++) begin
            setLine(line, fr[i]);
            stepN(bitclk);
        end
        setLine(line, 1'b1);
        stepN(gap);
    endtask

    task automatic sendByte(input logic [7:0] d, input logic stopv);
        applyStimulus(0, {7'b0, stopv, d}, 9, BITCLK, BITCLK);
    endtask

    task automatic popOne();
        ready = 1'b1;
        stepClk();
        ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rxi = 1'b1; rxi_p = 1'b1; ready = 1'b0; ready_p = 1'b0;
        stepN(4);
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_data", data, 0);
        checkOutput("rst_flags", {break_det, frame_err, parity_err}, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_p_valid_ovr", {valid_p, overrun_p}, 0);
        rst = 1'b0;
        stepN(40);

        // 8N1 0xA5 with ready held high
        ready = 1'b1;
        base = pop_cnt;
        sendByte(8'hA5, 1'b1);
        stepN(10);
        checkOutput("a5_count", pop_cnt - base, 1);
        checkOutput("a5_data", last_data, 8'hA5);
        checkOutput("a5_flags", last_flags, 0);
        checkOutput("a5_level", level, 0);
        ready = 1'b0;

        // Even parity: 0x03 with wrong then right parity bit
        applyStimulus(1, 16'h0303, 10, BITCLK, BITCLK);
        checkOutput("par_bad_level", level_p, 1);
        checkOutput("par_bad_data", data_p, 8'h03);
        checkOutput("par_bad_flags", {break_det_p, frame_err_p, parity_err_p}, 3'b001);
        ready_p = 1'b1; stepClk(); ready_p = 1'b0;
        checkOutput("par_pop_level", level_p, 0);
        applyStimulus(1, 16'h0203, 10, BITCLK, BITCLK);
        checkOutput("par_ok_data", data_p, 8'h03);
        checkOutput("par_ok_flags", {valid_p, break_det_p, frame_err_p, parity_err_p}, 4'b1000);
        ready_p = 1'b1; stepClk(); ready_p = 1'b0;

        // Short glitch is rejected, following frame still received
        rxi = 1'b0; stepN(5); rxi = 1'b1; stepN(64);
        checkOutput("glitch_level", level, 0);
        sendByte(8'h5A, 1'b1);
        checkOutput("after_glitch_data", data, 8'h5A);
        checkOutput("after_glitch_flags", {level, break_det, frame_err, parity_err}, {3'd1, 3'b000});
        popOne();

        // Framing error, then a long break, then a normal frame
        sendByte(8'h3C, 1'b0);
        checkOutput("fe_data", data, 8'h3C);
        checkOutput("fe_flags", {break_det, frame_err, parity_err}, 3'b010);
        popOne();
        rxi = 1'b0; stepN(30 * BITCLK); rxi = 1'b1; stepN(64);
        checkOutput("brk_level", level, 1);
        checkOutput("brk_data", data, 8'h00);
        checkOutput("brk_flags", {break_det, frame_err, parity_err}, 3'b110);
        popOne();
        sendByte(8'h11, 1'b1);
        checkOutput("post_brk_data", data, 8'h11);
        checkOutput("post_brk_flags", {level, break_det, frame_err, parity_err}, {3'd1, 3'b000});
        popOne();

        // Fill FIFO, overflow once, then push and pop together while full
        base = ovr_cnt;
        for (int i = 1; i <= 4; i++) sendByte(8'(i), 1'b1);
        checkOutput("full_level", level, 4);
        checkOutput("full_no_ovr", ovr_cnt - base, 0);
        sendByte(8'h05, 1'b1);
        checkOutput("ovr_pulse", ovr_cnt - base, 1);
        checkOutput("ovr_level", level, 4);
        checkOutput("ovr_head", data, 8'h01);
        offset = ovr_cyc - stim_cyc;
        fork
            sendByte(8'h07, 1'b1);
            begin
                stepN(offset);
                ready = 1'b1;
                stepClk();
                ready = 1'b0;
            end
        join
        checkOutput("pushpop_no_ovr", ovr_cnt - base, 1);
        checkOutput("pushpop_popped", last_data, 8'h01);
        checkOutput("pushpop_level", level, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_data", data, drain_exp[i]);
            popOne();
        end
        checkOutput("drain_empty", {valid, level}, 0);
        base = pop_cnt;
        ready = 1'b1; stepN(3); ready = 1'b0;
        checkOutput("empty_pop", pop_cnt - base, 0);
        checkOutput("empty_pop_level", level, 0);

        // Baud mismatch bursts: 3% slow then 3% fast
        ready = 1'b1;
        base = pop_cnt; base2 = non55;
        for (int i = 0; i < 10; i++) applyStimulus(0, 16'h0155, 9, 33, 16);
        stepN(40);
        checkOutput("slow_count", pop_cnt - base, 10);
        checkOutput("slow_bad", non55 - base2, 0);
        base = pop_cnt; base2 = non55;
        for (int i = 0; i < 10; i++) applyStimulus(0, 16'h0155, 9, 31, 16);
        stepN(40);
        checkOutput("fast_count", pop_cnt - base, 10);
        checkOutput("fast_bad", non55 - base2, 0);
        ready = 1'b0;

        // Reset in the middle of a frame with one entry queued
        sendByte(8'h22, 1'b1);
        checkOutput("pre_rst_level", level, 1);
        rxi = 1'b0; stepN(100);
        rst = 1'b1; stepN(2); rst = 1'b0; stepClk();
        checkOutput("mid_rst_state", {valid, level}, 0);
        stepN(100);
        rxi = 1'b1; stepN(64);
        checkOutput("low_after_rst", level, 0);
        sendByte(8'hC3, 1'b1);
        checkOutput("post_rst_data", data, 8'hC3);
        checkOutput("post_rst_flags", {level, break_det, frame_err, parity_err}, {3'd1, 3'b000});
        popOne();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
